// File: rtl/i2s_rcvr_deserializer_pkg.sv
// Shared types and constants for the I2S receive deserializer.
//   state_t  : framing state machine encoding (SYNC, LEFT, RIGHT)
//   CH_LEFT  : ws level that selects the left channel
//   CH_RIGHT : ws level that selects the right channel
//   WS_RESET : value the remembered ws level takes on reset
package i2s_rcvr_pkg;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;
  localparam logic WS_RESET = 1'b1;

endpackage

// File: rtl/i2s_rcvr_deserializer_if.sv
// Parallel stereo sample bus between the deserializer and the sample FIFO.
//   sample_left/sample_right : held frame, DATA_W bits per channel
//   sample_valid             : held frame is valid
//   sample_ready             : consumer accepts when valid & ready
//   overrun                  : one-cycle pulse when a completed frame is dropped
// modport master : producer (deserializer)
// modport slave  : consumer (FIFO)
interface i2s_rcvr_deserializer_if #(
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] sample_left;
  logic [DATA_W-1:0] sample_right;
  logic              sample_valid;
  logic              sample_ready;
  logic              overrun;

  modport master (
    output sample_left,
    output sample_right,
    output sample_valid,
    output overrun,
    input  sample_ready
  );

  modport slave (
    input  sample_left,
    input  sample_right,
    input  sample_valid,
    input  overrun,
    output sample_ready
  );

endinterface

// File: rtl/i2s_rcvr_deserializer_word_assembler.sv
// MSB-first word assembler with left-justification into DATA_W bits.
//   clk, n_rst  : clock, asynchronous active-low reset
//   strobe      : update the word register this cycle
//   bit_in      : serial bit of this strobe
//   clear_after : start a new word after this strobe
//   include_bit : append bit_in to the current word; when clear_after is set
//                 and include_bit is clear, bit_in instead becomes the MSB of
//                 the new word (left-justified framing)
//   word_now    : the current word including bit_in when include_bit is set
// Bits beyond DATA_W are discarded; unfilled LSBs stay zero.
module i2s_word_assembler #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              strobe,
  input  logic              bit_in,
  input  logic              clear_after,
  input  logic              include_bit,
  output logic [DATA_W-1:0] word_now
);

  localparam int                CNT_W   = $clog2(DATA_W + 1);
  localparam logic [DATA_W-1:0] MSB_ONE = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] word_next;
  logic [DATA_W-1:0] bit_mask;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_now;
  logic [CNT_W-1:0]  cnt_next;

  // The mask walks down from the MSB and becomes zero once bit_cnt reaches
  // DATA_W, so saturation also handles truncation of long words.
  always_comb begin
    bit_mask = MSB_ONE >> cnt_q;
    word_now = word_q;
    cnt_now  = cnt_q;
    if (include_bit && (cnt_q < CNT_W'(DATA_W))) begin
      if (bit_in) begin
        word_now = word_q | bit_mask;
      end
      cnt_now = cnt_q + CNT_W'(1);
    end
    word_next = '0;
    cnt_next  = '0;
    if (!include_bit) begin
      word_next = bit_in ? MSB_ONE : '0;
      cnt_next  = CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else if (strobe) begin
      if (clear_after) begin
        word_q <= word_next;
        cnt_q  <= cnt_next;
      end else begin
        word_q <= word_now;
        cnt_q  <= cnt_now;
      end
    end
  end

endmodule

// File: rtl/i2s_rcvr_deserializer.sv
// I2S receive deserializer: assembles left/right words from the shift strobe,
// sdata and ws, and offers each completed stereo frame on a valid/ready bus.
//   clk, n_rst : clock, asynchronous active-low reset
//   shift      : one-cycle strobe qualifying sdata and ws
//   sdata      : serial data, MSB first
//   ws         : word select (0 = left, 1 = right)
//   smp        : sample bus (sample_left, sample_right, sample_valid,
//                sample_ready, overrun)
// Build option: define I2S_RCVR_LJ_EN for left-justified framing (no 1-bit
// delay); otherwise standard I2S framing.
module i2s_rcvr_deserializer
  import i2s_rcvr_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     shift,
  input  logic                     sdata,
  input  logic                     ws,
  i2s_rcvr_deserializer_if.master  smp
);

`ifdef I2S_RCVR_LJ_EN
  localparam logic LJ_MODE = 1'b1;
`else
  localparam logic LJ_MODE = 1'b0;
`endif

  state_t            state_q, state_d;
  logic              ws_prev_q;
  logic              transition;
  logic              asm_strobe, asm_clear, asm_include;
  logic              load_left, frame_done;
  logic [DATA_W-1:0] word_now;
  logic [DATA_W-1:0] left_hold_q;
  logic [DATA_W-1:0] left_q, right_q;
  logic              valid_q, overrun_q;

  i2s_word_assembler #(.DATA_W(DATA_W)) u_assembler (
    .clk         (clk),
    .n_rst       (n_rst),
    .strobe      (asm_strobe),
    .bit_in      (sdata),
    .clear_after (asm_clear),
    .include_bit (asm_include),
    .word_now    (word_now)
  );

  assign transition = (ws != ws_prev_q);

  // On a channel change, standard I2S appends the strobe's bit to the ending
  // word; left-justified framing instead starts the new word with it.
  always_comb begin
    state_d     = state_q;
    asm_strobe  = 1'b0;
    asm_clear   = 1'b0;
    asm_include = 1'b1;
    load_left   = 1'b0;
    frame_done  = 1'b0;
    if (shift) begin
      case (state_q)
        SYNC: begin
          if (transition && (ws == CH_LEFT)) begin
            asm_strobe  = 1'b1;
            asm_clear   = 1'b1;
            asm_include = ~LJ_MODE;
            state_d     = LEFT;
          end
        end
        LEFT: begin
          asm_strobe = 1'b1;
          if (transition && (ws == CH_RIGHT)) begin
            asm_clear   = 1'b1;
            asm_include = ~LJ_MODE;
            load_left   = 1'b1;
            state_d     = RIGHT;
          end
        end
        RIGHT: begin
          asm_strobe = 1'b1;
          if (transition && (ws == CH_LEFT)) begin
            asm_clear   = 1'b1;
            asm_include = ~LJ_MODE;
            frame_done  = 1'b1;
            state_d     = LEFT;
          end
        end
        default: state_d = SYNC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= SYNC;
      ws_prev_q   <= WS_RESET;
      left_hold_q <= '0;
    end else begin
      state_q <= state_d;
      if (shift) begin
        ws_prev_q <= ws;
      end
      if (load_left) begin
        left_hold_q <= word_now;
      end
    end
  end

  // A new frame may replace the held one only if the slot is empty or being
  // accepted in the same cycle; otherwise the new frame is dropped.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (frame_done) begin
        if (!valid_q || smp.sample_ready) begin
          left_q  <= left_hold_q;
          right_q <= word_now;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && smp.sample_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign smp.sample_left  = left_q;
  assign smp.sample_right = right_q;
  assign smp.sample_valid = valid_q;
  assign smp.overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_rcvr_deserializer.sv
// Self-checking bench for i2s_rcvr_deserializer (DATA_W = 16).
// Frames expected by the stimulus are queued; a monitor compares each frame
// the DUT hands over (valid & ready) against the queue head.
// Honours I2S_RCVR_LJ_EN to build the matching serial framing.
module tb_i2s_rcvr_deserializer;

  localparam int DW = 16;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  logic shift = 1'b0;
  logic sdata = 1'b0;
  logic ws    = 1'b1;

  i2s_rcvr_deserializer_if #(.DATA_W(DW)) smp_if ();

  i2s_rcvr_deserializer #(.DATA_W(DW)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .shift (shift),
    .sdata (sdata),
    .ws    (ws),
    .smp   (smp_if)
  );

  always #5 clk = ~clk;

  int n_vec        = 0;
  int n_miss       = 0;
  int valid_cycles = 0;
  int ov_seen      = 0;

  logic [DW-1:0] exp_left_q[$];
  logic [DW-1:0] exp_right_q[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor_outputs();
    logic [DW-1:0] el;
    logic [DW-1:0] er;
    forever begin
      @(negedge clk);
      if (n_rst) begin
        if (smp_if.sample_valid) valid_cycles++;
        if (smp_if.overrun) ov_seen++;
        if (smp_if.sample_valid && smp_if.sample_ready) begin
          if (exp_left_q.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("[TB] FAIL unexpected_frame: got 0x%0h/0x%0h, expected no frame",
                     smp_if.sample_left, smp_if.sample_right);
          end else begin
            el = exp_left_q.pop_front();
            er = exp_right_q.pop_front();
            check_output("frame_left", 32'(smp_if.sample_left), 32'(el));
            check_output("frame_right", 32'(smp_if.sample_right), 32'(er));
          end
        end
      end
    end
  endtask

  task automatic expect_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    exp_left_q.push_back(l);
    exp_right_q.push_back(r);
  endtask

  task automatic send_bit(input logic d, input logic w, input logic rdy_set);
    @(posedge clk);
    #1;
    shift = 1'b1;
    sdata = d;
    ws    = w;
    if (rdy_set) smp_if.sample_ready = 1'b1;
    @(posedge clk);
    #1;
    shift = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] value, input int n, input logic ws_body,
                           input logic ws_last, input logic rdy_last);
    for (int i = n - 1; i >= 0; i--) begin
      send_bit(value[i], (i == 0) ? ws_last : ws_body, (i == 0) && rdy_last);
    end
  endtask

  task automatic send_sync();
`ifdef I2S_RCVR_LJ_EN
    send_bit(1'b0, 1'b1, 1'b0);
`else
    send_bit(1'b0, 1'b1, 1'b0);
    send_bit(1'b1, 1'b0, 1'b0);
`endif
  endtask

  // rdy_end raises sample_ready on the strobe that completes the frame.
  task automatic apply_stimulus(input logic [31:0] l, input logic [31:0] r, input int n,
                                input logic last, input logic rdy_end);
`ifdef I2S_RCVR_LJ_EN
    send_word(l, n, 1'b0, 1'b0, 1'b0);
    send_word(r, n, 1'b1, 1'b1, 1'b0);
    if (last) send_bit(1'b0, 1'b0, rdy_end);
`else
    send_word(l, n, 1'b0, 1'b1, 1'b0);
    send_word(r, n, 1'b1, 1'b0, rdy_end);
    if (last) begin end
`endif
  endtask

  task automatic do_reset();
    shift = 1'b0;
    sdata = 1'b0;
    ws    = 1'b1;
    n_rst = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    n_rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_left_q.size() != 0; i++) @(negedge clk);
    repeat (2) @(negedge clk);
    check_output("drain_pending", 32'(exp_left_q.size()), 32'd0);
  endtask

  initial begin
    fork
      monitor_outputs();
      begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 500000 ns");
        $fatal(1, "[TB] watchdog expired");
      end
    join_none

    smp_if.sample_ready = 1'b1;
    #12;
    check_output("rst_left", 32'(smp_if.sample_left), 32'd0);
    check_output("rst_right", 32'(smp_if.sample_right), 32'd0);
    check_output("rst_valid", 32'(smp_if.sample_valid), 32'd0);
    check_output("rst_overrun", 32'(smp_if.overrun), 32'd0);

    $display("[TB] standard 16-bit frame");
    do_reset();
    valid_cycles = 0;
    ov_seen = 0;
    send_sync();
    expect_frame(16'hA5C3, 16'h1234);
    apply_stimulus(32'hA5C3, 32'h1234, 16, 1'b1, 1'b0);
    drain();
    check_output("valid_cycles", 32'(valid_cycles), 32'd1);
    check_output("no_overrun", 32'(ov_seen), 32'd0);

    $display("[TB] short 8-bit words");
    do_reset();
    send_sync();
    expect_frame(16'hFF00, 16'h8100);
    apply_stimulus(32'hFF, 32'h81, 8, 1'b1, 1'b0);
    drain();

    $display("[TB] long 20-bit words");
    do_reset();
    send_sync();
    expect_frame(16'hABCD, 16'h1234);
    apply_stimulus(32'hABCDE, 32'h12345, 20, 1'b1, 1'b0);
    drain();

    $display("[TB] backpressure");
    do_reset();
    ov_seen = 0;
    send_sync();
    smp_if.sample_ready = 1'b0;
    expect_frame(16'h1111, 16'h2222);
    apply_stimulus(32'h1111, 32'h2222, 16, 1'b0, 1'b0);
    apply_stimulus(32'h3333, 32'h4444, 16, 1'b0, 1'b0);
    check_output("bp_valid", 32'(smp_if.sample_valid), 32'd1);
    check_output("bp_hold_left", 32'(smp_if.sample_left), 32'h1111);
    check_output("bp_hold_right", 32'(smp_if.sample_right), 32'h2222);
    expect_frame(16'h5A5A, 16'hC3C3);
    apply_stimulus(32'h5A5A, 32'hC3C3, 16, 1'b1, 1'b1);
    drain();
    check_output("bp_overrun_pulses", 32'(ov_seen), 32'd1);

    $display("[TB] reset mid right word");
    do_reset();
    send_sync();
    smp_if.sample_ready = 1'b0;
    apply_stimulus(32'h0F0F, 32'hF0F0, 16, 1'b1, 1'b0);
    send_word(32'h7777, 16, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b1, 1'b0);
    check_output("pre_rst_valid", 32'(smp_if.sample_valid), 32'd1);
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check_output("mid_rst_valid", 32'(smp_if.sample_valid), 32'd0);
    check_output("mid_rst_left", 32'(smp_if.sample_left), 32'd0);
    check_output("mid_rst_right", 32'(smp_if.sample_right), 32'd0);
    #3;
    n_rst = 1'b1;
    smp_if.sample_ready = 1'b1;
    valid_cycles = 0;
    for (int i = 0; i < 20; i++) send_bit(i[0], 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check_output("no_frame_before_sync", 32'(valid_cycles), 32'd0);
    send_sync();
    expect_frame(16'h9ABC, 16'hDEF0);
    apply_stimulus(32'h9ABC, 32'hDEF0, 16, 1'b1, 1'b0);
    drain();

    $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/i2s_rcvr_deserializer.md
Name: i2s_rcvr_deserializer

Overview:
Downstream of the I2S receiver input controller. Consumes its one-cycle `shift` strobe together with the serial data and word-select lines. Assembles MSB-first left/right channel words and presents each completed stereo frame as a parallel pair on a valid/ready interface to the audio sample FIFO.
- One frame is a left word followed by a right word.
- Word length on the wire may differ from DATA_W. Words are left-justified into DATA_W: truncated if longer, zero-padded in the LSBs if shorter.

Parameters:
DATA_W, 16, width of each output channel sample (legal range 8..32).

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
shift  in  1  one-cycle strobe; sdata and ws are sampled only in cycles where shift=1
sdata  in  1  I2S serial data, MSB first
ws  in  1  word select; 0=left channel, 1=right channel
sample_left  out  DATA_W  left sample of the held frame
sample_right  out  DATA_W  right sample of the held frame
sample_valid  out  1  held frame is valid
sample_ready  in  1  consumer accepts the frame when sample_valid & sample_ready
overrun  out  1  one-cycle pulse: a completed frame was dropped
Interface note: reset n_rst, asynchronous, active-low; clock clk.

Behaviour:
- Reset values: sample_left=0, sample_right=0, sample_valid=0, overrun=0. Internal state=SYNC, ws_prev=1, bit_cnt=0, shift/hold registers=0.
- Nothing changes on cycles where shift=0, except the output handshake.
- Transition detection: on a strobe, a transition exists when the sampled ws != ws_prev. ws_prev then updates to the sampled ws.
- Standard I2S (1-bit delay): on a transition strobe, the sampled sdata is the final bit of the ending word.
  - Append that bit, then close the word.
  - The next strobe carries the MSB of the new word.
- Bit placement:
  - At word start the word register is cleared and bit_cnt=0.
  - Each appended bit goes to index DATA_W-1-bit_cnt, then bit_cnt increments.
  - bit_cnt saturates at DATA_W; further bits are discarded (truncation).
  - Unfilled LSBs remain 0.
- State machine:
  - SYNC: discard all bits. On a ws 1->0 transition go to LEFT with a cleared word; the bit on that strobe is discarded.
  - LEFT: append bits. On a ws 0->1 transition, append the bit, copy the word to left_hold, clear the word, go to RIGHT.
  - RIGHT: append bits. On a ws 1->0 transition, append the bit, then set frame_done with (left_hold, word), clear the word, go to LEFT.
- Output stage, evaluated in the frame_done cycle:
  - If sample_valid=0, or sample_valid & sample_ready: load the outputs; sample_valid=1 from the next cycle.
  - Otherwise: the new frame is dropped, the held frame is unchanged, and overrun=1 for exactly one cycle.
- Handshake:
  - sample_valid stays high and the outputs stay stable until accepted.
  - Acceptance without a new frame_done clears sample_valid next cycle.
  - Acceptance and frame_done in the same cycle: new frame loaded, sample_valid stays 1, no overrun.
- Latency: outputs update on the clk edge after the strobe cycle that completes the right word.
- A zero-length word (transition on the first strobe of a word) yields a word containing only that final bit at the MSB.
- Asynchronous reset mid-word returns to SYNC and drops the partial frame and any held-but-unaccepted frame.

Optional Feature:
I2S_RCVR_LJ_EN:
- Defined: left-justified format, with no 1-bit delay.
  - On a transition strobe, close the ending word without the current bit.
  - The current bit becomes the MSB of the new word.
  - In SYNC, the 1->0 transition bit is kept as the left MSB.
- Undefined: standard I2S as described in Behaviour.

Decomposition:
- Package i2s_rcvr_pkg:
  - state enum (SYNC, LEFT, RIGHT)
  - constants CH_LEFT=1'b0 and CH_RIGHT=1'b1
  - WS_RESET=1'b1
- Sub-module i2s_word_assembler (parameter DATA_W):
  - inputs: strobe, bit, clear_after, include_bit
  - holds the word register and saturating bit_cnt
  - outputs: the word as it stands including the current bit, and the cleared next word
- The top level holds the FSM, left_hold, and the output/handshake registers.

Test Plan:
- Reset, then SYNC alignment, then standard frame. ws=1 then 0, then left 0xA5C3 and right 0x1234, each 16 bits, DATA_W=16, sample_ready=1 -> exactly one frame with sample_left=0xA5C3, sample_right=0x1234; sample_valid high 1 cycle.
- Short words: 8-bit words 0xFF/0x81 -> sample_left=0xFF00, sample_right=0x8100.
- Long words: 20-bit words 0xABCDE/0x12345 -> sample_left=0xABCD, sample_right=0x1234.
- Backpressure: sample_ready=0 across two frames (F1=0x1111/0x2222, F2=0x3333/0x4444) -> outputs hold F1, overrun pulses once at F2 completion, F2 lost. Then assert sample_ready with F3 completing in the same cycle -> F3 loaded, sample_valid stays 1, overrun=0.
- Reset mid-right-word: drop n_rst with a frame held -> all outputs 0 immediately. The first frame after reset is emitted only after a fresh ws 1->0 transition.
- With I2S_RCVR_LJ_EN: the same bitstream shifted one strobe earlier relative to ws -> identical output values to scenario 1.
